// File: rtl/crc_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crc_frame_checker                                            |
// | Description : Receive-side CRC-8 / even-parity frame checker. Consumes a   |
// |               byte stream framed by in_last, where the last byte of each   |
// |               frame is the transmitted CRC-8. It recomputes the CRC over   |
// |               the payload, checks per-byte even parity, and emits one      |
// |               registered result record per frame.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk            in   1      rising-edge clock                             |
// |   reset_n        in   1      asynchronous active-low reset                 |
// |   clr            in   1      synchronous abort of the frame in progress    |
// |   in_valid       in   1      input byte valid                              |
// |   in_ready       out  1      checker can accept a byte                     |
// |   in_data        in   8      payload byte, or CRC byte when in_last=1      |
// |   in_parity      in   1      even-parity bit for in_data                   |
// |   in_last        in   1      byte is the frame's trailing CRC byte         |
// |   res_valid      out  1      result record valid                           |
// |   res_ready      in   1      downstream accepts the result                 |
// |   res_crc_ok     out  1      computed payload CRC matches CRC byte         |
// |   res_parity_err out  1      at least one byte had bad parity              |
// |   res_len        out  LEN_W  payload byte count, saturating                |
// |   res_len_ovf    out  1      payload longer than 2^LEN_W-1 bytes           |
// |   err_cnt        out  ERR_W  count of bad frames, saturating               |
// +----------------------------------------------------------------------------+
module crc_frame_checker #(
  parameter logic [7:0] POLY  = 8'h07,
  parameter logic [7:0] INIT  = 8'h00,
  parameter int         LEN_W = 8,
  parameter int         ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_parity,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_crc_ok,
  output logic             res_parity_err,
  output logic [LEN_W-1:0] res_len,
  output logic             res_len_ovf,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RX     = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             par_q, par_d;
  logic             res_crc_ok_q, res_crc_ok_d;
  logic             res_parity_err_q, res_parity_err_d;
  logic [LEN_W-1:0] res_len_q, res_len_d;
  logic             res_len_ovf_q, res_len_ovf_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             accept;
  logic             byte_par_err;
  logic [7:0]       crc_next;

  // One full byte of MSB-first CRC-8 division.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  assign crc_next     = crc8_byte(crc_q, in_data);
  assign in_ready     = (state_q != S_REPORT);
  // clr wins over an offered byte, so a byte presented with clr is dropped.
  assign accept       = in_valid && in_ready && !clr;
  assign byte_par_err = ^{in_data, in_parity};

  always_comb begin
    state_d          = state_q;
    crc_d            = crc_q;
    len_d            = len_q;
    ovf_d            = ovf_q;
    par_d            = par_q;
    res_crc_ok_d     = res_crc_ok_q;
    res_parity_err_d = res_parity_err_q;
    res_len_d        = res_len_q;
    res_len_ovf_d    = res_len_ovf_q;
    err_cnt_d        = err_cnt_q;

    if (clr) begin
      state_d          = S_IDLE;
      crc_d            = INIT;
      len_d            = '0;
      ovf_d            = 1'b0;
      par_d            = 1'b0;
      res_crc_ok_d     = 1'b0;
      res_parity_err_d = 1'b0;
      res_len_d        = '0;
      res_len_ovf_d    = 1'b0;
    end else begin
      case (state_q)
        // IDLE and RX differ only in name: the accumulators are already at
        // their start values whenever IDLE is entered.
        S_IDLE, S_RX: begin
          if (accept) begin
            if (in_last) begin
              // The CRC byte is compared, never folded into the running CRC.
              state_d          = S_REPORT;
              res_crc_ok_d     = (crc_q == in_data);
              res_parity_err_d = par_q | byte_par_err;
              res_len_d        = len_q;
              res_len_ovf_d    = ovf_q;
              if ((!res_crc_ok_d || res_parity_err_d) && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
              end
            end else begin
              state_d = S_RX;
              crc_d   = crc_next;
              par_d   = par_q | byte_par_err;
              if (len_q == LEN_MAX) begin
                ovf_d = 1'b1;
              end else begin
                len_d = len_q + 1'b1;
              end
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            state_d = S_IDLE;
            crc_d   = INIT;
            len_d   = '0;
            ovf_d   = 1'b0;
            par_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          crc_d   = INIT;
          len_d   = '0;
          ovf_d   = 1'b0;
          par_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      crc_q            <= INIT;
      len_q            <= '0;
      ovf_q            <= 1'b0;
      par_q            <= 1'b0;
      res_crc_ok_q     <= 1'b0;
      res_parity_err_q <= 1'b0;
      res_len_q        <= '0;
      res_len_ovf_q    <= 1'b0;
      err_cnt_q        <= '0;
    end else begin
      state_q          <= state_d;
      crc_q            <= crc_d;
      len_q            <= len_d;
      ovf_q            <= ovf_d;
      par_q            <= par_d;
      res_crc_ok_q     <= res_crc_ok_d;
      res_parity_err_q <= res_parity_err_d;
      res_len_q        <= res_len_d;
      res_len_ovf_q    <= res_len_ovf_d;
      err_cnt_q        <= err_cnt_d;
    end
  end

  // res_valid is a decode of the state register, so it is glitch-free and
  // drops on the edge that leaves REPORT.
  assign res_valid      = (state_q == S_REPORT);
  assign res_crc_ok     = res_crc_ok_q;
  assign res_parity_err = res_parity_err_q;
  assign res_len        = res_len_q;
  assign res_len_ovf    = res_len_ovf_q;
  assign err_cnt        = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_crc_frame_checker                                         |
// | Description : Scoreboard bench for crc_frame_checker. Frames are issued    |
// |               by a driver; a reference model predicts each result record  |
// |               and a monitor pops and compares when res_valid is seen.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_crc_frame_checker;

  localparam logic [7:0] POLY = 8'h07;
  localparam logic [7:0] INIT = 8'h00;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic       crc_ok;
    logic       par_err;
    logic [7:0] len;
    logic       ovf;
    logic [7:0] err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_parity = 1'b0;
  logic       in_last = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic       res_crc_ok;
  logic       res_parity_err;
  logic [7:0] res_len;
  logic       res_len_ovf;
  logic [7:0] err_cnt;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   exp_err = 0;
  int   results_seen = 0;
  bit   rdy_rand = 1'b0;
  logic rdy_force = 1'b1;
  exp_t cur;
  bit   have_cur = 1'b0;

  always #5 clk = ~clk;

  crc_frame_checker #(.POLY(POLY), .INIT(INIT), .LEN_W(8), .ERR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_crc_ok(res_crc_ok), .res_parity_err(res_parity_err),
    .res_len(res_len), .res_len_ovf(res_len_ovf), .err_cnt(err_cnt)
  );

  // Reference CRC: bit-serial polynomial long division over the message.
  function automatic logic [7:0] ref_crc(input bq_t msg);
    logic [7:0] r;
    logic [7:0] b;
    logic       fb;
    r = INIT;
    foreach (msg[k]) begin
      b = msg[k];
      for (int j = 7; j >= 0; j--) begin
        fb = r[7] ^ b[j];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ POLY;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready: either forced by the main sequence or randomised.
  always @(posedge clk) begin
    #1;
    res_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Monitor: pops one expected record per result, then checks it stays stable.
  always @(negedge clk) begin
    if (!reset_n) begin
      have_cur = 1'b0;
    end else if (res_valid) begin
      chk("in_ready_low_in_report", {31'b0, in_ready}, 32'd0);
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: res_valid=1 with no frame outstanding");
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          results_seen++;
        end
      end
      if (have_cur) begin
        chk("res_crc_ok", {31'b0, res_crc_ok}, {31'b0, cur.crc_ok});
        chk("res_parity_err", {31'b0, res_parity_err}, {31'b0, cur.par_err});
        chk("res_len", {24'b0, res_len}, {24'b0, cur.len});
        chk("res_len_ovf", {31'b0, res_len_ovf}, {31'b0, cur.ovf});
        chk("err_cnt", {24'b0, err_cnt}, {24'b0, cur.err});
      end
      if (res_ready) have_cur = 1'b0;
    end
  end

  // Drive one byte; returns 1 ns after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] d, input logic p, input logic l);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_data = d; in_parity = p; in_last = l;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles", guard);
      $fatal(1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // bad_idx selects which byte gets wrong parity (-1 none, pl.size() = CRC byte).
  task automatic send_frame(input bq_t pl, input int bad_idx, input logic [7:0] crc_b);
    exp_t e;
    foreach (pl[k]) send_byte(pl[k], (k == bad_idx) ? ~^pl[k] : ^pl[k], 1'b0);
    send_byte(crc_b, (bad_idx == pl.size()) ? ~^crc_b : ^crc_b, 1'b1);
    e.crc_ok  = (ref_crc(pl) == crc_b);
    e.par_err = (bad_idx >= 0);
    e.len     = (pl.size() > 255) ? 8'hFF : 8'(pl.size());
    e.ovf     = (pl.size() > 255);
    if ((!e.crc_ok || e.par_err) && exp_err < 255) exp_err++;
    e.err     = 8'(exp_err);
    exp_q.push_back(e);
    @(negedge clk);
    chk("latency_res_valid", {31'b0, res_valid}, 32'd1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || res_valid) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bq_t pl;
    int  n;
    int  bad;
    int  seen0;
    logic [7:0] cb;

    // 1: reset
    repeat (3) @(negedge clk);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_rst_res_valid", {31'b0, res_valid}, 32'd0);
    @(posedge clk); #1;

    // 2: "123456789" with correct CRC 0xF4
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    send_frame(pl, -1, 8'hF4);
    drain();

    // 3: wrong CRC, result held for 5 cycles
    rdy_force = 1'b0;
    @(posedge clk); #1;
    send_frame(pl, -1, 8'hF5);
    repeat (5) @(negedge clk);
    rdy_force = 1'b1;
    drain();
    chk("err_cnt_after_bad_crc", {24'b0, err_cnt}, 32'd1);

    // 4: parity error on payload, CRC good
    pl = {};
    pl.push_back(8'h01);
    send_frame(pl, 0, 8'h07);
    drain();

    // 5: zero-payload frame, then 256-byte payload (length saturation)
    pl = {};
    send_frame(pl, -1, 8'h00);
    drain();
    for (int i = 0; i < 256; i++) pl.push_back(8'h00);
    send_frame(pl, -1, 8'h00);
    drain();

    // 6: clr aborts a partial frame; only the following frame reports
    seen0 = results_seen;
    send_byte(8'hA5, ^8'hA5, 1'b0);
    send_byte(8'h3C, ^8'h3C, 1'b0);
    send_byte(8'h77, ^8'h77, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", {31'b0, in_ready}, 32'd1);
    chk("clr_res_valid", {31'b0, res_valid}, 32'd0);
    @(posedge clk); #1;
    pl = {};
    pl.push_back(8'h01);
    send_frame(pl, -1, 8'h07);
    drain();
    chk("clr_result_count", results_seen - seen0, 32'd1);

    // Randomised frames with random downstream backpressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(0, 12);
      pl = {};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
      bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n) : -1;
      cb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : ref_crc(pl);
      send_frame(pl, bad, cb);
    end
    drain();
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    @(posedge clk); #1;
    chk("final_err_cnt", {24'b0, err_cnt}, 32'(exp_err));

    // Async reset while a result is pending
    rdy_force = 1'b0;
    @(posedge clk); #1;
    pl = {};
    pl.push_back(8'h01);
    send_frame(pl, -1, 8'h00);
    #2;
    reset_n = 1'b0;
    exp_err = 0;
    #1;
    chk("async_rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("async_rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    rdy_force = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_rst_no_result", {31'b0, res_valid}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
